conv_encoder: RTL and testbench

//  Rate-1/2, K=3 convolutional encoder: the transmit end of the Viterbi link.

---
 rtl/conv_encoder.sv | 194 +++++++++++++++++++
 tb/tb_conv_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_encoder
//  Description : Rate-1/2, K=3 convolutional encoder feeding the Viterbi link.
//                Accepts one frame of FRAME_LEN data bits through a
//                valid/ready handshake. Each accepted bit produces one 2-bit
//                symbol {G0 parity, G1 parity} in a single-stage output
//                register with back-pressure.
//
//                Optional feature macro: CONV_ENC_TAIL_EN
//                  defined   : K-1 zero tail bits are appended after the data
//                              so the frame ends in encoder state 0.
//                  undefined : the frame ends after the last data symbol and
//                              the final encoder state is left unterminated.
//
//  Ports       : clk          rising-edge clock
//                rst          synchronous active-high reset
//                start_i      frame-open pulse, honoured only while idle
//                din_i        data bit
//                din_valid_i  din_i is valid
//                din_ready_o  encoder takes din_i this cycle
//                sym_o        encoded symbol {G0 out, G1 out}
//                sym_valid_o  sym_o is valid
//                sym_ready_i  downstream takes sym_o
//                sym_last_o   marks the final symbol of the frame
//                busy_o       high whenever a frame is in progress
//
//  Revision    : 1.0  initial release
// ============================================================================
module conv_encoder #(
    parameter int             K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter int             FRAME_LEN = 8,
    parameter int             CNT_W     = $clog2(FRAME_LEN + K)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       din_i,
    input  logic       din_valid_i,
    output logic       din_ready_o,
    output logic [1:0] sym_o,
    output logic       sym_valid_o,
    input  logic       sym_ready_i,
    output logic       sym_last_o,
    output logic       busy_o
);

`ifdef CONV_ENC_TAIL_EN
    localparam int c_tail_len = K - 1;
`else
    localparam int c_tail_len = 0;
`endif
    localparam int c_total = FRAME_LEN + c_tail_len;

    // Counter indices of the last data symbol and of the last frame symbol.
    localparam logic [CNT_W-1:0] c_data_last  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(c_total - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_encode = 2'd1;
`ifdef CONV_ENC_TAIL_EN
    localparam logic [1:0] c_st_flush  = 2'd2;
`endif
    localparam logic [1:0] c_st_drain  = 2'd3;

    logic [1:0]       r_fsm;
    logic [1:0]       w_fsm_next;
    logic [K-2:0]     r_enc_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sym;
    logic             r_sym_valid;
    logic             r_sym_last;

    logic             w_load_ok;
    logic             w_in_flush;
    logic             w_din_ready;
    logic             w_accept;
    logic             w_flush_load;
    logic             w_load;
    logic             w_bit;
    logic [K-1:0]     w_sr;
    logic [1:0]       w_sym;
    logic             w_is_last;

    // The output register can take a new symbol when empty or being drained.
    assign w_load_ok = !r_sym_valid || sym_ready_i;
    assign w_accept  = w_din_ready && din_valid_i;
    assign w_load    = w_accept || w_flush_load;

    // Tail bits are forced to zero; din_i is ignored outside ENCODE anyway.
    assign w_bit     = din_i & ~w_in_flush;
    assign w_sr      = {w_bit, r_enc_state};
    assign w_sym     = {^(w_sr & G0), ^(w_sr & G1)};
    assign w_is_last = (r_cnt == c_frame_last);

    // ---------------------------------------------------------------- FSM reg
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= c_st_idle;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_st_idle: begin
                if (start_i) begin
                    w_fsm_next = c_st_encode;
                end
            end
            c_st_encode: begin
                if (w_accept && (r_cnt == c_data_last)) begin
`ifdef CONV_ENC_TAIL_EN
                    w_fsm_next = c_st_flush;
`else
                    w_fsm_next = c_st_drain;
`endif
                end
            end
`ifdef CONV_ENC_TAIL_EN
            c_st_flush: begin
                if (w_flush_load && w_is_last) begin
                    w_fsm_next = c_st_drain;
                end
            end
`endif
            c_st_drain: begin
                // The final symbol sits in the output register until taken.
                if (r_sym_valid && sym_ready_i) begin
                    w_fsm_next = c_st_idle;
                end
            end
            default: begin
                w_fsm_next = c_st_idle;
            end
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        w_din_ready  = (r_fsm == c_st_encode) && w_load_ok;
        busy_o       = (r_fsm != c_st_idle);
`ifdef CONV_ENC_TAIL_EN
        w_in_flush   = (r_fsm == c_st_flush);
`else
        w_in_flush   = 1'b0;
`endif
        w_flush_load = w_in_flush && w_load_ok;
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_state <= '0;
            r_cnt       <= '0;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
        end else begin
            if ((r_fsm == c_st_idle) && start_i) begin
                r_enc_state <= '0;
                r_cnt       <= '0;
            end else if (w_load) begin
                r_enc_state <= w_sr[K-1:1];
                // Saturate on the final symbol so the count never wraps.
                if (!w_is_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (w_load) begin
                r_sym       <= w_sym;
                r_sym_valid <= 1'b1;
                r_sym_last  <= w_is_last;
            end else if (sym_ready_i) begin
                // Symbol value is kept; only the qualifiers drop.
                r_sym_valid <= 1'b0;
                r_sym_last  <= 1'b0;
            end
        end
    end

    assign din_ready_o = w_din_ready;
    assign sym_o       = r_sym;
    assign sym_valid_o = r_sym_valid;
    assign sym_last_o  = r_sym_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_encoder
//  Description : Self-checking bench for conv_encoder. Two instances are
//                used: FRAME_LEN=4 for directed frames and FRAME_LEN=8 for
//                randomized frames. Expected symbols come from a direct
//                parity model of the generator polynomials 7 and 5 (octal)
//                over the input bit sequence, with zero tail bits appended
//                when CONV_ENC_TAIL_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_encoder;

`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start     [2];
    logic       din       [2];
    logic       din_valid [2];
    logic       din_ready [2];
    logic [1:0] sym       [2];
    logic       sym_valid [2];
    logic       sym_ready [2];
    logic       sym_last  [2];
    logic       busy      [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_encoder #(.FRAME_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start[0]), .din_i(din[0]),
        .din_valid_i(din_valid[0]), .din_ready_o(din_ready[0]),
        .sym_o(sym[0]), .sym_valid_o(sym_valid[0]), .sym_ready_i(sym_ready[0]),
        .sym_last_o(sym_last[0]), .busy_o(busy[0])
    );

    conv_encoder #(.FRAME_LEN(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start[1]), .din_i(din[1]),
        .din_valid_i(din_valid[1]), .din_ready_o(din_ready[1]),
        .sym_o(sym[1]), .sym_valid_o(sym_valid[1]), .sym_ready_i(sym_ready[1]),
        .sym_last_o(sym_last[1]), .busy_o(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input int idx, input string tag);
        check({tag, "_sym"},       32'(sym[idx]),       32'd0);
        check({tag, "_sym_valid"}, 32'(sym_valid[idx]), 32'd0);
        check({tag, "_sym_last"},  32'(sym_last[idx]),  32'd0);
        check({tag, "_din_ready"}, 32'(din_ready[idx]), 32'd0);
        check({tag, "_busy"},      32'(busy[idx]),      32'd0);
    endtask

    // rmode: 0 = ready always high, 1 = 3-cycle stall on symbol 2, 2 = random
    // abort_after >= 0 stops after that many symbols have been taken.
    task automatic run_frame(input int idx, input int n, input logic [15:0] bits,
                             input int rmode, input bit vrand, input bit poke_start,
                             input int abort_after);
        logic [1:0] exp_sym [0:31];
        logic       u0, u1, u2;
        int         total, bi, k, cyc, stall;
        logic       prev_hold;
        logic [1:0] prev_sym;
        logic       prev_last;

        total = n + TAIL;
        for (int j = 0; j < total; j++) begin
            u0 = (j < n) ? bits[j] : 1'b0;
            u1 = (j >= 1 && j - 1 < n) ? bits[j-1] : 1'b0;
            u2 = (j >= 2 && j - 2 < n) ? bits[j-2] : 1'b0;
            exp_sym[j] = {u0 ^ u1 ^ u2, u0 ^ u2};
        end

        bi = 0; k = 0; cyc = 0; stall = 0;
        prev_hold = 1'b0; prev_sym = 2'b00; prev_last = 1'b0;

        // Start cycle with din_valid also high: no bit may be taken here.
        @(posedge clk); #1;
        start[idx] = 1'b1; din_valid[idx] = 1'b1; din[idx] = bits[0];
        sym_ready[idx] = 1'b1;
        @(negedge clk);
        check("din_ready_in_start_cycle", 32'(din_ready[idx]), 32'd0);
        @(posedge clk); #1;
        start[idx] = 1'b0;
        din_valid[idx] = 1'b1; din[idx] = bits[0];

        while (k < total && cyc < 200 && !(abort_after >= 0 && k >= abort_after)) begin
            @(negedge clk);
            if (cyc == 0) check("busy_in_frame", 32'(busy[idx]), 32'd1);
            if (prev_hold) begin
                check("stall_valid_stable", 32'(sym_valid[idx]), 32'd1);
                check("stall_sym_stable",   32'(sym[idx]),       32'(prev_sym));
                check("stall_last_stable",  32'(sym_last[idx]),  32'(prev_last));
            end
            check("din_ready_gated", 32'(din_ready[idx] & sym_valid[idx] & ~sym_ready[idx]), 32'd0);
            if (bi >= n) check("din_ready_after_data", 32'(din_ready[idx]), 32'd0);
            if (din_ready[idx] && din_valid[idx]) bi++;
            if (sym_valid[idx] && sym_ready[idx]) begin
                check("sym_value", 32'(sym[idx]),      32'(exp_sym[k]));
                check("sym_last",  32'(sym_last[idx]), 32'(k == total - 1));
                k++;
            end
            prev_hold = sym_valid[idx] && !sym_ready[idx];
            prev_sym  = sym[idx];
            prev_last = sym_last[idx];

            @(posedge clk); #1;
            cyc++;
            case (rmode)
                0: sym_ready[idx] = 1'b1;
                1: begin
                    if (k == 1 && stall < 3) begin
                        sym_ready[idx] = 1'b0;
                        stall++;
                    end else begin
                        sym_ready[idx] = 1'b1;
                    end
                end
                default: sym_ready[idx] = ($urandom_range(0, 3) != 0);
            endcase
            din_valid[idx] = (bi < n) && (!vrand || ($urandom_range(0, 3) != 0));
            din[idx]       = (bi < n) ? bits[bi] : 1'($urandom);
            start[idx]     = poke_start && (cyc == 2);
        end

        start[idx] = 1'b0;
        if (abort_after >= 0 && k >= abort_after) return;
        if (k < total) check("frame_timeout_symbols", 32'(k), 32'(total));

        @(negedge clk);
        check("busy_after_last",  32'(busy[idx]),      32'd0);
        check("valid_after_last", 32'(sym_valid[idx]), 32'd0);
        check("sym_kept_after",   32'(sym[idx]),       32'(exp_sym[total-1]));
        din_valid[idx] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; din[i] = 1'b0; din_valid[i] = 1'b0; sym_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs(0, "reset4");
        check_idle_outputs(1, "reset8");
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 1,0,1,1 with continuous ready.
        run_frame(0, 4, 16'b1101, 0, 1'b0, 1'b0, -1);
        // Same frame with a 3-cycle stall on symbol 2.
        run_frame(0, 4, 16'b1101, 1, 1'b0, 1'b0, -1);

        // Reset after two symbols, then the same frame again.
        run_frame(0, 4, 16'b1101, 0, 1'b0, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs(0, "midframe_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; din_valid[i] = 1'b0;
        end
        run_frame(0, 4, 16'b1101, 0, 1'b0, 1'b0, -1);

        // Mid-frame start pulse must be ignored.
        run_frame(0, 4, 16'b0110, 0, 1'b0, 1'b1, -1);

        // Randomized frames on the FRAME_LEN=8 instance.
        for (int f = 0; f < 20; f++) begin
            run_frame(1, 8, 16'($urandom), 2, 1'b1, 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
